// File: rtl/fir_dma_pkg.sv
// fir_dma_pkg: shared state encoding and request constants for the FIR SDRAM DMA engine.
package fir_dma_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int ADDR_STEP = 4;
  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;
endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock FIFO; push is honoured when full only if a pop frees the slot the same cycle.
module dma_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem_q[rp_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fir_sdram_dma.sv
// fir_sdram_dma: reads len words to the FIR input stream and writes FIR results back through one arbiter port.
// Define FIR_DMA_PREFETCH_HINT_EN to drive mem_prefetch_step on sequential reads; otherwise it is tied low.
module fir_sdram_dma
  import fir_dma_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [LEN_W-1:0]  len,
  output logic              dma_busy,
  output logic              done,
  output logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tvalid,
  input  logic              ss_tready,
  input  logic [DATA_W-1:0] sm_tdata,
  input  logic              sm_tvalid,
  output logic              sm_tready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_in_valid,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_out_valid,
  output logic              mem_prefetch_step
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C = CW'(MAX_OUTST);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LEN_W-1:0] len_q, rd_issued_q, wr_rcvd_q;
  logic [CW-1:0] outst_q, rf_count, wf_count;
  logic lock_q, lock_rw_q;
  logic run, launch, rd_ok, wr_ok, req_kind, acc, rd_acc, wr_acc, ret, last_wr;
  logic rf_full, rf_empty, rf_pop, wf_full, wf_empty, wf_push;
  logic [DATA_W-1:0] rf_dout, wf_dout;
  assign run = state_q == RUN;
  assign launch = (state_q == IDLE) & start;
  assign rd_ok = run & (rd_issued_q < len_q) & (({1'b0, outst_q} + {1'b0, rf_count}) < DEPTH_C)
               & (outst_q < MAXO_C);
  assign wr_ok = run & ~wf_empty;
  // A stalled request keeps its kind so a newly eligible write cannot displace a pending read.
  assign req_kind = lock_q ? lock_rw_q : (wr_ok ? REQ_WR : REQ_RD);
  assign mem_in_valid = lock_q | wr_ok | rd_ok;
  assign acc = mem_in_valid & ~mem_busy;
  assign rd_acc = acc & (req_kind == REQ_RD);
  assign wr_acc = acc & (req_kind == REQ_WR);
  assign mem_rw = mem_in_valid ? req_kind : REQ_RD;
  assign mem_addr = ~mem_in_valid ? '0 : (req_kind == REQ_WR) ? wr_addr_q : rd_addr_q;
  assign mem_wdata = (mem_in_valid & (req_kind == REQ_WR)) ? wf_dout : '0;
  assign ret = run & mem_out_valid;
  assign ss_tvalid = ~rf_empty;
  assign ss_tdata = rf_empty ? '0 : rf_dout;
  assign rf_pop = ss_tvalid & ss_tready;
  assign sm_tready = run & ~wf_full & (wr_rcvd_q < len_q);
  assign wf_push = sm_tvalid & sm_tready;
  // Final write: every result received and this is the only one left queued.
  assign last_wr = wr_acc & (wr_rcvd_q == len_q) & (wf_count == CW'(1));
  assign dma_busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    if (launch) state_d = (len == '0) ? DONE : RUN;
    if (run && last_wr) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q <= '0;
      rd_issued_q <= '0;
      wr_rcvd_q <= '0;
      outst_q <= '0;
      lock_q <= 1'b0;
      lock_rw_q <= REQ_RD;
    end else begin
      state_q <= state_d;
      if (launch) begin
        rd_addr_q <= rd_base;
        wr_addr_q <= wr_base;
        len_q <= len;
        rd_issued_q <= '0;
        wr_rcvd_q <= '0;
      end
      if (rd_acc) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(ADDR_STEP);
        rd_issued_q <= rd_issued_q + LEN_W'(1);
      end
      if (wr_acc) wr_addr_q <= wr_addr_q + ADDR_W'(ADDR_STEP);
      if (wf_push) wr_rcvd_q <= wr_rcvd_q + LEN_W'(1);
      outst_q <= outst_q + CW'(rd_acc) - CW'(ret);
      lock_q <= mem_in_valid & mem_busy;
      lock_rw_q <= req_kind;
    end
  end
`ifdef FIR_DMA_PREFETCH_HINT_EN
  logic prev_rd_q;
  always_ff @(posedge clk) begin
    if (rst || launch) prev_rd_q <= 1'b0;
    else if (rd_acc) prev_rd_q <= 1'b1;
  end
  assign mem_prefetch_step = mem_in_valid & (req_kind == REQ_RD) & prev_rd_q;
`else
  assign mem_prefetch_step = 1'b0;
`endif
  dma_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rfifo (
    .clk(clk), .rst(rst), .push(ret & ~rf_full), .din(mem_rdata), .pop(rf_pop),
    .dout(rf_dout), .full(rf_full), .empty(rf_empty), .count(rf_count)
  );
  dma_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_wfifo (
    .clk(clk), .rst(rst), .push(wf_push), .din(sm_tdata), .pop(wr_acc),
    .dout(wf_dout), .full(wf_full), .empty(wf_empty), .count(wf_count)
  );
endmodule
